// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter muxing NUM_REQ req/ack producers (req_i, data_i, ack_o) onto one FIFO write port (fifo_wr_en_o, fifo_data_o, fifo_full_i), reporting owner_o and busy_o
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*DATA_W-1:0]    data_i,
  output logic [NUM_REQ-1:0]           ack_o,
  input  logic                         fifo_full_i,
  output logic                         fifo_wr_en_o,
  output logic [DATA_W-1:0]            fifo_data_o,
  output logic [$clog2(NUM_REQ)-1:0]   owner_o,
  output logic                         busy_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [IW-1:0] ptr, owner, rr, sel;
  logic [CW-1:0] cnt, nc;
  logic rr_ok, keep, acc, start;
  always_comb begin
    rr = '0;
    rr_ok = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_i[(int'(ptr) + i) % NUM_REQ]) begin
        rr = IW'((int'(ptr) + i) % NUM_REQ);
        rr_ok = 1'b1;
      end
    end
  end
  assign keep = state == BURST && req_i[owner];
  assign sel = keep ? owner : rr;
  assign acc = (keep | rr_ok) & ~fifo_full_i & ~rst;
  assign start = state == IDLE || sel != owner;
  assign nc = start ? CW'(1) : cnt + CW'(1);
  assign ack_o = acc ? NUM_REQ'(1) << sel : '0;
  assign fifo_wr_en_o = acc;
  assign fifo_data_o = data_i[int'(sel) * DATA_W +: DATA_W];
  assign owner_o = owner;
  assign busy_o = state == BURST;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= IW'(NUM_REQ - 1);
      owner <= '0;
      cnt <= '0;
    end else if (acc) begin
      owner <= sel;
      ptr <= sel;
      cnt <= nc;
      state <= nc == CW'(BURST_MAX) ? IDLE : BURST;
    end else if (state == BURST && !fifo_full_i) begin
      state <= IDLE;
      cnt <= '0;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter against a behavioural model
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int BM = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] data = '0;
  logic full = 1'b0;
  logic [N-1:0] ack;
  logic wr_en;
  logic [W-1:0] fdata;
  logic [$clog2(N)-1:0] owner;
  logic busy;
  int checks = 0;
  int errors = 0;
  int m_ptr = N - 1;
  int m_owner = 0;
  int m_beats = 0;
  bit m_busy = 1'b0;
  bit m_valid = 1'b0;
  int m_gnt = -1;
  bit use_fifo = 1'b0;
  int dut_idx[$];
  logic [W-1:0] fq[$];
  int exp_q[$];
  always #5 clk = ~clk;
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req_i(req), .data_i(data), .ack_o(ack),
    .fifo_full_i(full), .fifo_wr_en_o(wr_en), .fifo_data_o(fdata),
    .owner_o(owner), .busy_o(busy)
  );
  function automatic int pick();
    if (m_busy && req[m_owner]) return m_owner;
    for (int k = 1; k <= N; k++) if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  function automatic int onehot_idx(logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    int g;
    bit a;
    g = pick();
    a = g >= 0 && !full && !rst;
    check("ack", {28'd0, ack}, a ? 32'(1 << g) : 32'd0);
    check("wr_en", {31'd0, wr_en}, {31'd0, a});
    if (a) check("data", {24'd0, fdata}, {24'd0, data[g*W +: W]});
    if (m_valid) begin
      check("owner", {30'd0, owner}, 32'(m_owner));
      check("busy", {31'd0, busy}, {31'd0, m_busy});
    end
    if (wr_en === 1'b1) begin
      dut_idx.push_back(onehot_idx(ack));
      if (use_fifo) fq.push_back(fdata);
    end
  end
  task automatic step();
    int g;
    @(posedge clk);
    g = pick();
    m_gnt = -1;
    if (rst) begin
      m_ptr = N - 1;
      m_owner = 0;
      m_beats = 0;
      m_busy = 1'b0;
      m_valid = 1'b1;
    end else if (g >= 0 && !full) begin
      m_gnt = g;
      if (!m_busy || g != m_owner) begin
        m_owner = g;
        m_ptr = g;
        m_beats = 0;
      end
      m_beats++;
      m_busy = m_beats < BM;
    end else if (!full) begin
      m_busy = 1'b0;
      m_beats = 0;
    end
    #1;
    if (use_fifo) full = fq.size() >= 8;
  endtask
  task automatic reset_seq();
    rst = 1'b1;
    req = '0;
    full = 1'b0;
    step();
    rst = 1'b0;
    dut_idx.delete();
  endtask
  task automatic expect_order(string name);
    check($sformatf("%s_count", name), dut_idx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dut_idx.size(); i++)
      check($sformatf("%s_grant%0d", name, i), dut_idx[i], exp_q[i]);
  endtask
  initial begin
    int n0, n1;
    step();
    reset_seq();
    check("reset_owner", {30'd0, owner}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      data[7:0] = 8'(8'h10 + i);
      step();
    end
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    expect_order("single");
    check("single_busy_end", {31'd0, busy}, 32'd0);
    reset_seq();
    data = 32'hA3A2A1A0;
    req = 4'b1111;
    repeat (12) step();
    exp_q = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    expect_order("fair");
    reset_seq();
    data = 32'h33221100;
    req = 4'b1110;
    repeat (2) step();
    req = 4'b1100;
    repeat (5) step();
    exp_q = '{1, 1, 2, 2, 2, 2, 3};
    expect_order("release");
    reset_seq();
    data = 32'h5B5A5150;
    req = 4'b0011;
    repeat (2) step();
    full = 1'b1;
    repeat (3) step();
    full = 1'b0;
    repeat (3) step();
    exp_q = '{0, 0, 0, 0, 1};
    expect_order("backpressure");
    reset_seq();
    data = 32'h00C20000;
    req = 4'b0100;
    repeat (2) step();
    data[7:0] = 8'h0F;
    req = 4'b0101;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_owner", {30'd0, owner}, 32'd0);
    step();
    exp_q = '{2, 2, 0};
    expect_order("midrst");
    reset_seq();
    fq.delete();
    use_fifo = 1'b1;
    n0 = 0;
    n1 = 0;
    req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      data[7:0] = 8'(8'h40 + n0);
      data[15:8] = 8'(8'h80 + n1);
      step();
      if (m_gnt == 0) n0++;
      if (m_gnt == 1) n1++;
    end
    check("fifo_writes", dut_idx.size(), 32'd8);
    check("fifo_full", {31'd0, full}, 32'd1);
    exp_q = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h80, 32'h81, 32'h82, 32'h83};
    check("fifo_depth", fq.size(), 32'd8);
    for (int i = 0; i < 8 && fq.size() > 0; i++) check($sformatf("fifo_word%0d", i), {24'd0, fq.pop_front()}, exp_q[i]);
    use_fifo = 1'b0;
    reset_seq();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (m_gnt == k || !req[k]) begin
          req[k] = $urandom_range(1) == 1;
          data[k*W +: W] = 8'($urandom);
        end
      end
      full = $urandom_range(3) == 0;
      rst = $urandom_range(199) == 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
